// File: rtl/wishbone_slave_adapter_posted.sv
// wishbone_slave_adapter_posted
//   Wishbone classic slave that fronts a simple register-mapped peripheral.
//   Writes are posted into a small FIFO and acked at once. A drain engine
//   forwards queued writes to the peripheral in issue order. Reads wait until
//   the FIFO has drained, so a read never overtakes an earlier write. Reads
//   then go to the peripheral through a ready handshake.
//   Unmapped word indices and empty byte selects are answered with wb_err_o.
//   An optional idle cycle follows every termination.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   wb_addr_i/data_i/sel_i    Wishbone request (byte address, write data, selects)
//   wb_we_i/stb_i/cyc_i       Wishbone classic controls
//   wb_data_o                 registered read data (holds the last completed read)
//   wb_ack_o / wb_err_o       normal / error termination
//   p_req_o/we_o/addr_o       peripheral access request, direction, word index
//   p_wdata_o/be_o            peripheral write data and byte enables
//   p_rdata_i / p_ready_i     peripheral read data, access completion
//   busy_o                    FIFO non-empty or peripheral read in flight
module wishbone_slave_adapter_posted #(
  parameter int DATA_W      = 32,
  parameter int P_ADDR_W    = 2,
  parameter int NUM_REGS    = 4,
  parameter int WFIFO_DEPTH = 4,
  parameter int COOLDOWN    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  output logic [DATA_W-1:0]     wb_data_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  p_req_o,
  output logic                  p_we_o,
  output logic [P_ADDR_W-1:0]   p_addr_o,
  output logic [DATA_W-1:0]     p_wdata_o,
  output logic [DATA_W/8-1:0]   p_be_o,
  input  logic [DATA_W-1:0]     p_rdata_i,
  input  logic                  p_ready_i,
  output logic                  busy_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LSB   = $clog2(BE_W);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(WFIFO_DEPTH);
  localparam logic [P_ADDR_W:0]   NUM_REGS_W = (P_ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_RWAIT, S_RREQ, S_ACK, S_ERR, S_COOL
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [P_ADDR_W-1:0]    rd_addr_reg;
  logic [BE_W-1:0]        rd_be_reg;
  logic [DATA_W-1:0]      rdata_reg;
  logic                   abort_reg;

  logic [P_ADDR_W-1:0]    fifo_addr_mem [WFIFO_DEPTH];
  logic [DATA_W-1:0]      fifo_data_mem [WFIFO_DEPTH];
  logic [BE_W-1:0]        fifo_be_mem   [WFIFO_DEPTH];

  logic [P_ADDR_W-1:0]    req_idx;
  logic                   req, req_err, fifo_full, fifo_empty, push, pop;
  logic                   unused_addr;

  assign req_idx    = wb_addr_i[P_ADDR_W+LSB-1:LSB];
  assign unused_addr = ^{wb_addr_i[31:P_ADDR_W+LSB], wb_addr_i[LSB-1:0]};
  assign req        = wb_stb_i & wb_cyc_i;
  assign req_err    = ({1'b0, req_idx} >= NUM_REGS_W) || (wb_sel_i == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  // Full is judged on the registered count only: a pop in the same cycle
  // does not let a waiting write slip in until the next cycle.
  assign push = (state_reg == S_IDLE) && req && !req_err && wb_we_i && !fifo_full;
  // RREQ is only entered with the FIFO empty, so a non-empty FIFO always
  // owns the peripheral port.
  assign pop  = !fifo_empty && p_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= req_idx;
      fifo_data_mem[wr_ptr_reg] <= wb_data_i;
      fifo_be_mem[wr_ptr_reg]   <= wb_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_addr_reg <= '0;
      rd_be_reg   <= '0;
      rdata_reg   <= '0;
      abort_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        S_IDLE: begin
          if (req) begin
            if (req_err) begin
              state_reg <= S_ERR;
            end else if (wb_we_i) begin
              if (!fifo_full) state_reg <= S_ACK;
            end else begin
              rd_addr_reg <= req_idx;
              rd_be_reg   <= wb_sel_i;
              abort_reg   <= 1'b0;
              // With nothing queued the read goes straight to the peripheral;
              // otherwise it parks in RWAIT until the writes have drained.
              state_reg   <= fifo_empty ? S_RREQ : S_RWAIT;
            end
          end
        end
        S_RWAIT: begin
          if (!wb_cyc_i)       state_reg <= S_IDLE;
          else if (fifo_empty) state_reg <= S_RREQ;
        end
        S_RREQ: begin
          // An abandoned read still completes on the peripheral side so the
          // handshake is never left half-done; its data is discarded.
          if (p_ready_i) begin
            if (abort_reg || !wb_cyc_i) begin
              state_reg <= S_IDLE;
            end else begin
              rdata_reg <= p_rdata_i;
              state_reg <= S_ACK;
            end
          end else if (!wb_cyc_i) begin
            abort_reg <= 1'b1;
          end
        end
        S_ACK, S_ERR: begin
          if (COOLDOWN != 0) state_reg <= S_COOL;
          else               state_reg <= S_IDLE;
        end
        S_COOL:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    p_req_o   = 1'b0;
    p_we_o    = 1'b0;
    p_addr_o  = '0;
    p_wdata_o = '0;
    p_be_o    = '0;
    if (state_reg == S_RREQ) begin
      p_req_o  = 1'b1;
      p_addr_o = rd_addr_reg;
      p_be_o   = rd_be_reg;
    end else if (!fifo_empty) begin
      p_req_o   = 1'b1;
      p_we_o    = 1'b1;
      p_addr_o  = fifo_addr_mem[rd_ptr_reg];
      p_wdata_o = fifo_data_mem[rd_ptr_reg];
      p_be_o    = fifo_be_mem[rd_ptr_reg];
    end
  end

  assign wb_data_o = rdata_reg;
  assign wb_ack_o  = (state_reg == S_ACK) && wb_cyc_i;
  assign wb_err_o  = (state_reg == S_ERR) && wb_cyc_i;
  assign busy_o    = !fifo_empty || (state_reg == S_RREQ);

endmodule

// File: tb/tb_wishbone_slave_adapter_posted.sv
module tb_wishbone_slave_adapter_posted;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
  logic [3:0]  wb_sel;
  logic        p_req, p_we, p_ready, busy;
  logic [2:0]  p_addr;
  logic [31:0] p_wdata, p_rdata;
  logic [3:0]  p_be;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_seen = 0, err_seen = 0, preq_seen = 0;

  logic [31:0] per_mem [8];
  logic [34:0] wr_log [$];

  always #5 clk = ~clk;

  wishbone_slave_adapter_posted #(
    .DATA_W(32), .P_ADDR_W(3), .NUM_REGS(4), .WFIFO_DEPTH(4), .COOLDOWN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_addr_i(wb_addr), .wb_data_i(wb_wdata), .wb_data_o(wb_rdata),
    .wb_we_i(wb_we), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_sel_i(wb_sel),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err),
    .p_req_o(p_req), .p_we_o(p_we), .p_addr_o(p_addr), .p_wdata_o(p_wdata),
    .p_be_o(p_be), .p_rdata_i(p_rdata), .p_ready_i(p_ready), .busy_o(busy)
  );

  function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Peripheral model: byte-enabled register file plus a log of every write it accepts.
  assign p_rdata = per_mem[p_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) per_mem[i] <= '0;
    end else if (p_req && p_ready && p_we) begin
      per_mem[p_addr] <= merge(per_mem[p_addr], p_wdata, p_be);
      wr_log.push_back({p_addr, p_wdata});
    end
  end

  always @(negedge clk) begin
    if (wb_ack) ack_seen  <= ack_seen + 1;
    if (wb_err) err_seen  <= err_seen + 1;
    if (p_req)  preq_seen <= preq_seen + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT in IDLE.
  task automatic bus_xfer(input logic [31:0] addr, input logic we, input logic [31:0] data,
                          input logic [3:0] sel, input int max_cyc,
                          output logic ack, output logic err, output logic [31:0] rd,
                          output int lat);
    ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
    wb_addr = addr; wb_we = we; wb_wdata = data; wb_sel = sel;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (wb_ack || wb_err) begin
        ack = wb_ack; err = wb_err; rd = wb_rdata; lat = n;
        break;
      end
    end
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    int          exp_lat;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  logic        g_ack, g_err, flag;
  logic [31:0] g_rd;
  int          g_lat, base_ack, base_err, base_preq, base_log;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                addr        we    data           sel   ack   err  lat chk  exp_data
    vecs[0] = '{32'h00, 1'b1, 32'h12345678, 4'hF, 1'b1, 1'b0, 2, 1'b0, 32'h0};
    vecs[1] = '{32'h00, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 3, 1'b1, 32'h12345678};
    vecs[2] = '{32'h04, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 3, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{32'h08, 1'b1, 32'hCAFEF00D, 4'h3, 1'b1, 1'b0, 2, 1'b0, 32'h0};
    vecs[4] = '{32'h08, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 3, 1'b1, 32'h0000F00D};
    vecs[5] = '{32'h08, 1'b1, 32'hAB000000, 4'h8, 1'b1, 1'b0, 2, 1'b0, 32'h0};
    vecs[6] = '{32'h08, 1'b0, 32'h0,        4'hF, 1'b1, 1'b0, 3, 1'b1, 32'hAB00F00D};
    vecs[7] = '{32'h10, 1'b0, 32'h0,        4'hF, 1'b0, 1'b1, 2, 1'b0, 32'h0};
    vecs[8] = '{32'h0C, 1'b1, 32'h77777777, 4'h0, 1'b0, 1'b1, 2, 1'b0, 32'h0};
    vecs[9] = '{32'h1C, 1'b1, 32'h88888888, 4'hF, 1'b0, 1'b1, 2, 1'b0, 32'h0};

    rst = 1'b1; wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_stb = 1'b0;
    wb_cyc = 1'b0; wb_sel = '0; p_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", wb_ack, 0);
    check("rst_err", wb_err, 0);
    check("rst_preq_we_busy", {p_req, p_we, busy}, 0);
    check("rst_rdata", wb_rdata, 0);
    check("rst_paddr_wdata_be", {p_addr, p_wdata, p_be}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single posted write with the peripheral always ready.
    p_ready = 1'b1;
    wb_addr = 32'h4; wb_wdata = 32'hDEADBEEF; wb_sel = 4'hF; wb_we = 1'b1;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    @(negedge clk);
    check("wr1_no_early_ack", wb_ack, 0);
    @(negedge clk);
    check("wr1_ack_t1", wb_ack, 1);
    check("wr1_preq_we_t1", {p_req, p_we}, 2'b11);
    check("wr1_paddr", p_addr, 1);
    check("wr1_pwdata", p_wdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("wr1_busy_t2", busy, 0);
    check("wr1_ack_one_cycle", wb_ack, 0);
    @(posedge clk); #1;
    $display("[TB] single write addr=0x4 done");

    // Table of single transactions, peripheral always ready.
    for (int i = 0; i < 10; i++) begin
      bus_xfer(vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].sel, 8, g_ack, g_err, g_rd, g_lat);
      $display("[TB] vec %0d addr=%0h we=%0b ack=%0b err=%0b lat=%0d rdata=%0h",
               i, vecs[i].addr, vecs[i].we, g_ack, g_err, g_lat, g_rd);
      check($sformatf("vec%0d_ack", i), g_ack, vecs[i].exp_ack);
      check($sformatf("vec%0d_err", i), g_err, vecs[i].exp_err);
      check($sformatf("vec%0d_lat", i), g_lat, vecs[i].exp_lat);
      if (vecs[i].chk_data) check($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_data);
    end

    // Five writes with the peripheral stalled: FIFO full on the fifth.
    p_ready = 1'b0;
    base_log = wr_log.size();
    for (int i = 0; i < 4; i++) begin
      bus_xfer(32'(i * 4), 1'b1, 32'hA0 + 32'(i), 4'hF, 8, g_ack, g_err, g_rd, g_lat);
      $display("[TB] fill write %0d ack=%0b", i, g_ack);
      check($sformatf("fill%0d_ack", i), g_ack, 1);
    end
    wb_addr = 32'h0; wb_wdata = 32'hA4; wb_sel = 4'hF; wb_we = 1'b1;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (wb_ack) flag = 1'b1;
    end
    check("full_no_ack", flag, 0);
    @(posedge clk); #1; p_ready = 1'b1;
    @(posedge clk); #1; p_ready = 1'b0;
    flag = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (wb_ack) begin flag = 1'b1; break; end
    end
    check("full_ack_after_pop", flag, 1);
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    p_ready = 1'b1;
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    check("drain_done", busy, 0);
    check("drain_count", wr_log.size() - base_log, 5);
    for (int i = 0; i < 5; i++) begin
      if (base_log + i < wr_log.size())
        check($sformatf("drain_order%0d", i), wr_log[base_log + i], {3'(i % 4), 32'hA0 + 32'(i)});
    end
    $display("[TB] five-write fill/drain done");
    @(posedge clk); #1;

    // Write then read; read must wait for the posted write to reach the peripheral.
    p_ready = 1'b0;
    base_log = wr_log.size();
    base_ack = ack_seen;
    bus_xfer(32'h8, 1'b1, 32'h11, 4'hF, 8, g_ack, g_err, g_rd, g_lat);
    check("wr_rd_write_ack", g_ack, 1);
    wb_addr = 32'hC; wb_we = 1'b0; wb_sel = 4'hF; wb_stb = 1'b1; wb_cyc = 1'b1;
    flag = 1'b0; g_ack = 1'b0; g_rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 3) p_ready = 1'b1;
      if (p_req && !p_we && (wr_log.size() == base_log)) flag = 1'b1;
      if (wb_ack) begin g_ack = 1'b1; g_rd = wb_rdata; break; end
    end
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    @(posedge clk); #1;
    $display("[TB] write-then-read ack=%0b rdata=%0h", g_ack, g_rd);
    check("wr_rd_read_ack", g_ack, 1);
    check("wr_rd_rdata", g_rd, 32'hA3);
    check("wr_rd_order", flag, 0);
    check("wr_rd_ack_count", ack_seen - base_ack, 2);
    if (wr_log.size() > base_log)
      check("wr_rd_write_reached", wr_log[base_log], {3'd2, 32'h11});
    else
      check("wr_rd_write_reached", 0, 1);

    // Errors: no peripheral traffic, one-cycle err, no ack.
    p_ready = 1'b1;
    base_ack = ack_seen; base_err = err_seen; base_preq = preq_seen;
    bus_xfer(32'h10, 1'b0, 32'h0, 4'hF, 8, g_ack, g_err, g_rd, g_lat);
    check("err_idx_flag", g_err, 1);
    bus_xfer(32'h4, 1'b1, 32'h99, 4'h0, 8, g_ack, g_err, g_rd, g_lat);
    check("err_sel0_flag", g_err, 1);
    check("err_cycles", err_seen - base_err, 2);
    check("err_no_ack", ack_seen - base_ack, 0);
    check("err_no_preq", preq_seen - base_preq, 0);
    $display("[TB] error responses done");

    // Abort during RREQ with the peripheral stalled.
    p_ready = 1'b0;
    base_ack = ack_seen;
    wb_addr = 32'h4; wb_we = 1'b0; wb_sel = 4'hF; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_rreq", {p_req, p_we, p_addr}, {1'b1, 1'b0, 3'd1});
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_read_held", {p_req, busy}, 2'b11);
    @(posedge clk); #1; p_ready = 1'b1;
    @(posedge clk); #1; p_ready = 1'b0;
    @(negedge clk);
    check("abort_released", {p_req, busy}, 2'b00);
    check("abort_rdata_kept", wb_rdata, 32'hA3);
    check("abort_no_ack", ack_seen - base_ack, 0);
    @(posedge clk); #1;
    p_ready = 1'b1;
    bus_xfer(32'h8, 1'b0, 32'h0, 4'hF, 8, g_ack, g_err, g_rd, g_lat);
    $display("[TB] post-abort read ack=%0b lat=%0d rdata=%0h", g_ack, g_lat, g_rd);
    check("abort_idle_lat", g_lat, 3);
    check("abort_next_rdata", g_rd, 32'h11);

    // Reset with two writes queued.
    p_ready = 1'b0;
    bus_xfer(32'h0, 1'b1, 32'h55, 4'hF, 8, g_ack, g_err, g_rd, g_lat);
    bus_xfer(32'h4, 1'b1, 32'h66, 4'hF, 8, g_ack, g_err, g_rd, g_lat);
    check("rst_q_busy_before", busy, 1);
    base_log = wr_log.size();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_q_preq_busy", {p_req, p_we, busy}, 0);
    check("rst_q_outputs", {wb_ack, wb_err, wb_rdata, p_addr, p_wdata, p_be}, 0);
    @(posedge clk); #1;
    rst = 1'b0; p_ready = 1'b1;
    base_preq = preq_seen;
    repeat (6) @(negedge clk);
    check("rst_q_no_writes", wr_log.size() - base_log, 0);
    check("rst_q_no_preq", preq_seen - base_preq, 0);
    $display("[TB] reset with queued writes done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
